// File: rtl/gcd_arbiter_if.sv
// Requester and gcd-engine signal bundle for gcd_arbiter.
// slave = arbiter side, master = requesters plus engine side.
interface gcd_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned IW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] u_in;
  logic [8*N_REQ-1:0] v_in;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         res_out;
  logic               err;
  logic               busy;
  logic [IW-1:0]      grant_id;
  logic               gcd_ld;
  logic [7:0]         gcd_u;
  logic [7:0]         gcd_v;
  logic               gcd_done;
  logic [7:0]         gcd_res;

  modport slave (
    input  req, u_in, v_in, gcd_done, gcd_res,
    output ack, res_out, err, busy, grant_id, gcd_ld, gcd_u, gcd_v
  );

  modport master (
    output req, u_in, v_in, gcd_done, gcd_res,
    input  ack, res_out, err, busy, grant_id, gcd_ld, gcd_u, gcd_v
  );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter/sequencer sharing one gcd engine among N_REQ requesters.
// Optional WAIT watchdog enabled by defining GCD_ARB_WATCHDOG_EN.
module gcd_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WD_CYCLES = 64
) (
  input  logic         clk,
  input  logic         resetb,
  gcd_arbiter_if.slave bus
);
  localparam int unsigned IW  = $clog2(N_REQ);
  localparam int unsigned DW  = 8;
  localparam int unsigned WDW = 7;

  if (N_REQ < 2 || N_REQ > 8 || WD_CYCLES < 1 || WD_CYCLES > 128) begin : g_bad_cfg
    $error("gcd_arbiter: N_REQ must be 2..8 and WD_CYCLES 1..128");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic [DW-1:0]     gcd_u_q, gcd_u_d;
  logic [DW-1:0]     gcd_v_q, gcd_v_d;
  logic [DW-1:0]     result_q, result_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DW-1:0]     res_out_q, res_out_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              gcd_ld_q, gcd_ld_d;
`ifdef GCD_ARB_WATCHDOG_EN
  logic [WDW-1:0]    wd_cnt_q, wd_cnt_d;
  logic              wd_err_c;
`endif

  logic [DW-1:0]     u_arr [N_REQ];
  logic [DW-1:0]     v_arr [N_REQ];
  logic              hit_c;
  logic [IW-1:0]     hit_idx_c;
  logic [IW:0]       scan_sum;
  logic [IW-1:0]     scan_idx;

  for (genvar i = 0; i < N_REQ; i++) begin : g_op
    assign u_arr[i] = bus.u_in[DW*i +: DW];
    assign v_arr[i] = bus.v_in[DW*i +: DW];
  end

  // First pending request at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin : p_scan
    hit_c     = 1'b0;
    hit_idx_c = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      scan_sum = (IW+1)'(rr_ptr_q) + (IW+1)'(off);
      if (scan_sum >= (IW+1)'(N_REQ)) begin
        scan_sum = scan_sum - (IW+1)'(N_REQ);
      end
      scan_idx = IW'(scan_sum);
      if (!hit_c && bus.req[scan_idx]) begin
        hit_c     = 1'b1;
        hit_idx_c = scan_idx;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin : p_next
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    gcd_u_d    = gcd_u_q;
    gcd_v_d    = gcd_v_q;
    result_d   = result_q;
`ifdef GCD_ARB_WATCHDOG_EN
    wd_cnt_d   = wd_cnt_q;
    wd_err_c   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (hit_c) begin
          grant_id_d = hit_idx_c;
          rr_ptr_d   = (hit_idx_c == IW'(N_REQ - 1)) ? '0 : hit_idx_c + IW'(1);
          gcd_u_d    = u_arr[hit_idx_c];
          gcd_v_d    = v_arr[hit_idx_c];
          // The engine never finishes on a zero operand, so answer it here.
          if (u_arr[hit_idx_c] == '0 || v_arr[hit_idx_c] == '0) begin
            result_d = u_arr[hit_idx_c] | v_arr[hit_idx_c];
            state_d  = S_RESP;
          end else begin
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
`ifdef GCD_ARB_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.gcd_done) begin
          result_d = bus.gcd_res;
          state_d  = S_RESP;
        end
`ifdef GCD_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WDW'(WD_CYCLES - 1)) begin
          result_d = '0;
          wd_err_c = 1'b1;
          state_d  = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    gcd_ld_d  = (state_d == S_LOAD);
    ack_d     = '0;
    res_out_d = '0;
    if (state_d == S_RESP) begin
      ack_d[grant_id_d] = 1'b1;
      res_out_d         = result_d;
    end
`ifdef GCD_ARB_WATCHDOG_EN
    err_d = (state_d == S_RESP) && wd_err_c;
`else
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge resetb) begin : p_regs
    if (!resetb) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      gcd_u_q    <= '0;
      gcd_v_q    <= '0;
      result_q   <= '0;
      ack_q      <= '0;
      res_out_q  <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      gcd_ld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      gcd_u_q    <= gcd_u_d;
      gcd_v_q    <= gcd_v_d;
      result_q   <= result_d;
      ack_q      <= ack_d;
      res_out_q  <= res_out_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      gcd_ld_q   <= gcd_ld_d;
    end
  end

`ifdef GCD_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge resetb) begin : p_wd
    if (!resetb) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  assign bus.ack      = ack_q;
  assign bus.res_out  = res_out_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;
  assign bus.gcd_ld   = gcd_ld_q;
  assign bus.gcd_u    = gcd_u_q;
  assign bus.gcd_v    = gcd_v_q;
endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: directed vector table plus
// round-robin, watchdog/hang and reset-in-WAIT sequences.
module tb_gcd_arbiter;
  logic clk = 1'b0;
  logic resetb;
  logic hang;

  gcd_arbiter_if #(.N_REQ(4)) bus ();

  gcd_arbiter #(.N_REQ(4), .WD_CYCLES(64)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Subtractive gcd engine; done stays high until the next load.
  logic [7:0] ex, ey;
  logic       erun;
  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ex <= '0; ey <= '0; erun <= 1'b0;
      bus.gcd_done <= 1'b0; bus.gcd_res <= '0;
    end else if (bus.gcd_ld) begin
      ex <= bus.gcd_u; ey <= bus.gcd_v; erun <= 1'b1; bus.gcd_done <= 1'b0;
    end else if (erun && !hang) begin
      if (ex == ey) begin
        bus.gcd_done <= 1'b1; bus.gcd_res <= ex; erun <= 1'b0;
      end else if (ex > ey) begin
        ex <= ex - ey;
      end else begin
        ey <= ey - ex;
      end
    end
  end

  typedef struct {
    int unsigned idx;
    logic [7:0]  u;
    logic [7:0]  v;
    logic [7:0]  res;
    int          exp_cyc;
    bit          exp_ld;
  } vec_t;

  vec_t vecs [7];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},      32'(bus.ack),      32'd0);
    check({tag, "_res_out"},  32'(bus.res_out),  32'd0);
    check({tag, "_err"},      32'(bus.err),      32'd0);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
    check({tag, "_gcd_ld"},   32'(bus.gcd_ld),   32'd0);
    check({tag, "_gcd_u"},    32'(bus.gcd_u),    32'd0);
    check({tag, "_gcd_v"},    32'(bus.gcd_v),    32'd0);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic run_single(input vec_t t);
    int unsigned ld_cnt = 0;
    int unsigned ld_cyc = 0;
    int unsigned ack_cyc = 0;
    logic [7:0]  ld_u = '0;
    logic [7:0]  ld_v = '0;
    bit          got = 1'b0;
    bit          nz_bad = 1'b0;
    logic [3:0]  ack_v = '0;
    logic [7:0]  res_v = '0;
    logic        err_v = 1'b0;
    logic [1:0]  gid = '0;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      bus.u_in[8*i +: 8] = 8'($urandom);
      bus.v_in[8*i +: 8] = 8'($urandom);
    end
    bus.u_in[8*t.idx +: 8] = t.u;
    bus.v_in[8*t.idx +: 8] = t.v;
    bus.req = '0;
    bus.req[t.idx] = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus.gcd_ld) begin
        ld_cnt++; ld_cyc = c; ld_u = bus.gcd_u; ld_v = bus.gcd_v;
      end
      if (bus.ack != '0) begin
        got = 1'b1; ack_cyc = c; ack_v = bus.ack; res_v = bus.res_out;
        err_v = bus.err; gid = bus.grant_id;
        break;
      end
      if (bus.res_out != '0 || bus.err) nz_bad = 1'b1;
    end
    bus.req = '0;
    check("ack_seen", 32'(got), 32'd1);
    check("ack_onehot", 32'(ack_v), 32'(4'(1) << t.idx));
    check("res_out", 32'(res_v), 32'(t.res));
    check("err", 32'(err_v), 32'd0);
    check("grant_id", 32'(gid), 32'(t.idx));
    check("res_zero_elsewhere", 32'(nz_bad), 32'd0);
    check("ld_count", ld_cnt, t.exp_ld ? 32'd1 : 32'd0);
    if (t.exp_cyc >= 0) check("ack_cycle", ack_cyc, 32'(t.exp_cyc));
    if (t.exp_ld) begin
      check("ld_cycle", ld_cyc, 32'd1);
      check("ld_u", 32'(ld_u), 32'(t.u));
      check("ld_v", 32'(ld_v), 32'(t.v));
    end
  endtask

  // order packs 3-bit expected requester indices, first grant in [2:0].
  task automatic run_rr(input logic [3:0] mask, input bit rearm, input int n,
                        input logic [14:0] order, input logic [7:0] u,
                        input logic [7:0] v, input logic [7:0] r);
    int k = 0;
    int pend = -1;
    int cyc = 0;
    int unsigned e;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      bus.u_in[8*i +: 8] = u;
      bus.v_in[8*i +: 8] = v;
    end
    bus.req = mask;
    while (k < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (pend >= 0) begin
        bus.req[pend] = 1'b1;
        pend = -1;
      end
      if (bus.ack != '0) begin
        e = 32'(order[3*k +: 3]);
        check("rr_ack", 32'(bus.ack), 32'(4'(1) << e));
        check("rr_res", 32'(bus.res_out), 32'(r));
        bus.req = bus.req & ~bus.ack;
        if (rearm && k < n - 1) pend = int'(e);
        k++;
      end
    end
    bus.req = '0;
    check("rr_ack_count", 32'(k), 32'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit busy_ok;
    bit no_ack;
    bit got;
    vec_t t;

    vecs[0] = '{0, 8'd48,  8'd18, 8'd6,  -1, 1'b1};
    vecs[1] = '{2, 8'd12,  8'd12, 8'd12,  4, 1'b1};
    vecs[2] = '{1, 8'd0,   8'd35, 8'd35,  1, 1'b0};
    vecs[3] = '{1, 8'd0,   8'd0,  8'd0,   1, 1'b0};
    vecs[4] = '{3, 8'd35,  8'd0,  8'd35,  1, 1'b0};
    vecs[5] = '{0, 8'd255, 8'd85, 8'd85, -1, 1'b1};
    vecs[6] = '{3, 8'd7,   8'd13, 8'd1,  -1, 1'b1};

    hang = 1'b0;
    bus.req = '0; bus.u_in = '0; bus.v_in = '0;
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    resetb = 1'b1;

    for (int i = 0; i < 7; i++) run_single(vecs[i]);

    // Fresh reset so the rotation starts from requester 0.
    @(negedge clk); resetb = 1'b0;
    @(negedge clk); resetb = 1'b1;
    run_rr(4'b1111, 1'b1, 5, {3'd0, 3'd3, 3'd2, 3'd1, 3'd0}, 8'd54, 8'd24, 8'd6);
    t = '{1, 8'd54, 8'd24, 8'd6, -1, 1'b1};
    run_single(t);
    run_rr(4'b0011, 1'b0, 2, {9'd0, 3'd1, 3'd0}, 8'd54, 8'd24, 8'd6);

    // Engine that never completes.
    wait_idle();
    hang = 1'b1;
    bus.u_in[8*2 +: 8] = 8'd9;
    bus.v_in[8*2 +: 8] = 8'd6;
    bus.req = 4'b0100;
`ifdef GCD_ARB_WATCHDOG_EN
    got = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        got = 1'b1;
        check("wd_ack_cycle", 32'(c), 32'd66);
        check("wd_ack", 32'(bus.ack), 32'd4);
        check("wd_err", 32'(bus.err), 32'd1);
        check("wd_res", 32'(bus.res_out), 32'd0);
        break;
      end
    end
    bus.req = '0;
    check("wd_ack_seen", 32'(got), 32'd1);
    hang = 1'b0;
    t = '{2, 8'd9, 8'd6, 8'd3, -1, 1'b1};
    run_single(t);
`else
    busy_ok = 1'b1;
    no_ack  = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.ack != '0) no_ack = 1'b0;
    end
    check("hang_busy_held", 32'(busy_ok), 32'd1);
    check("hang_no_ack", 32'(no_ack), 32'd1);
    hang = 1'b0;
    got = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        got = 1'b1;
        check("unhang_ack", 32'(bus.ack), 32'd4);
        check("unhang_res", 32'(bus.res_out), 32'd3);
        check("unhang_err", 32'(bus.err), 32'd0);
        break;
      end
    end
    bus.req = '0;
    check("unhang_ack_seen", 32'(got), 32'd1);
`endif

    // Reset while requester 1 waits on (200,150).
    wait_idle();
    bus.u_in[8*1 +: 8] = 8'd200;
    bus.v_in[8*1 +: 8] = 8'd150;
    bus.req = 4'b0010;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    resetb = 1'b0;
    #1;
    check_reset_outputs("midwait");
    @(negedge clk);
    bus.req = '0;
    no_ack = 1'b1;
    @(negedge clk);
    if (bus.ack != '0) no_ack = 1'b0;
    resetb = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ack != '0) no_ack = 1'b0;
    end
    check("midwait_no_ack", 32'(no_ack), 32'd1);
    // rr_ptr back at 0: requester 1 wins over 3.
    run_rr(4'b1010, 1'b0, 2, {9'd0, 3'd3, 3'd1}, 8'd200, 8'd150, 8'd50);
    t = '{3, 8'd200, 8'd150, 8'd50, -1, 1'b1};
    run_single(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
